// File: rtl/kuznechik_key_sequencer.sv
// rtl/kuznechik_key_sequencer.sv - multi-slot Kuznechik round-key store with forward/reverse key serving
module kuznechik_key_sequencer #(
  parameter int KEY_W  = 128,
  parameter int ROUNDS = 10,
  parameter int SLOTS  = 2,
  parameter int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_start,
  input  logic [SLOT_W-1:0]  load_slot,
  input  logic               kg_ready,
  input  logic [2*KEY_W-1:0] kg_pair,
  output logic               load_busy,
  output logic [SLOTS-1:0]   slot_valid,
  input  logic               start,
  input  logic [SLOT_W-1:0]  sel_slot,
  input  logic               decrypt,
  input  logic               key_next,
  output logic [KEY_W-1:0]   key_out,
  output logic               key_valid,
  output logic               seq_busy,
  output logic               done,
  output logic               err,
  output logic [1:0]         err_code
);
  localparam int IDX_W = $clog2(ROUNDS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);
  localparam logic [IDX_W-1:0] END_PTR  = IDX_W'(ROUNDS);

  typedef enum logic [1:0] {L_IDLE, L_WAIT, L_WR2} load_state_t;
  typedef enum logic       {S_IDLE, S_RUN}         serve_state_t;

  load_state_t  l_state, l_next;
  serve_state_t s_state, s_next;

  logic [KEY_W-1:0]  mem [SLOTS][ROUNDS];
  logic [SLOT_W-1:0] ld_slot, srv_slot;
  logic [IDX_W-1:0]  wr_ptr, wr_ptr_odd, rd_idx;
  logic [KEY_W-1:0]  held_key;
  logic              srv_rev;
  logic              ld_collide, ld_accept, ld_take, ld_wr2, ld_finish, overrun;
  logic              srv_accept, srv_reject, deliver, last_key;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_state <= L_IDLE;
      s_state <= S_IDLE;
    end else begin
      l_state <= l_next;
      s_state <= s_next;
    end
  end

  always_comb begin
    l_next = l_state;
    case (l_state)
      L_IDLE:  if (ld_accept) l_next = L_WAIT;
      L_WAIT:  if (kg_ready) l_next = L_WR2;
      L_WR2:   l_next = ld_finish ? L_IDLE : L_WAIT;
      default: l_next = L_IDLE;
    endcase
    s_next = s_state;
    if (s_state == S_IDLE) begin
      if (srv_accept) s_next = S_RUN;
    end else if (deliver && last_key) begin
      s_next = S_IDLE;
    end
  end

  always_comb begin
    load_busy  = (l_state != L_IDLE);
    seq_busy   = (s_state == S_RUN);
    wr_ptr_odd = wr_ptr + IDX_W'(1);
    ld_collide = load_start && (l_state == L_IDLE) && seq_busy && (load_slot == srv_slot);
    ld_accept  = load_start && (l_state == L_IDLE) && !ld_collide;
    ld_take    = kg_ready && (l_state == L_WAIT);
    ld_wr2     = (l_state == L_WR2);
    ld_finish  = ld_wr2 && ((wr_ptr + IDX_W'(2)) == END_PTR);
    overrun    = kg_ready && (l_state != L_WAIT);
    // A slot whose load is starting this very cycle counts as being loaded.
    srv_accept = start && (s_state == S_IDLE) && slot_valid[sel_slot]
                 && !(load_busy && (ld_slot == sel_slot))
                 && !(ld_accept && (load_slot == sel_slot));
    srv_reject = start && (s_state == S_IDLE) && !srv_accept;
    deliver    = key_next && (s_state == S_RUN);
    last_key   = srv_rev ? (rd_idx == '0) : (rd_idx == LAST_IDX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_slot    <= '0;
      srv_slot   <= '0;
      wr_ptr     <= '0;
      rd_idx     <= '0;
      held_key   <= '0;
      srv_rev    <= 1'b0;
      slot_valid <= '0;
      key_out    <= '0;
      key_valid  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'd0;
    end else begin
      key_valid <= deliver;
      done      <= deliver && last_key;
      if (ld_accept) begin
        ld_slot               <= load_slot;
        wr_ptr                <= '0;
        slot_valid[load_slot] <= 1'b0;
      end
      if (ld_take) held_key <= kg_pair[KEY_W-1:0];
      if (ld_wr2) wr_ptr <= wr_ptr + IDX_W'(2);
      if (ld_finish) slot_valid[ld_slot] <= 1'b1;
      if (srv_accept) begin
        srv_slot <= sel_slot;
        srv_rev  <= decrypt;
        rd_idx   <= decrypt ? LAST_IDX : '0;
      end
      if (deliver) begin
        key_out <= mem[srv_slot][rd_idx];
        rd_idx  <= srv_rev ? rd_idx - IDX_W'(1) : rd_idx + IDX_W'(1);
      end
      // Highest code wins when several causes coincide.
      err <= overrun || ld_collide || srv_reject;
      if (overrun)         err_code <= 2'd3;
      else if (ld_collide) err_code <= 2'd2;
      else if (srv_reject) err_code <= 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (ld_take) mem[ld_slot][wr_ptr] <= kg_pair[2*KEY_W-1:KEY_W];
    if (ld_wr2) mem[ld_slot][wr_ptr_odd] <= held_key;
  end
endmodule

// File: tb/tb_kuznechik_key_sequencer.sv
// tb/tb_kuznechik_key_sequencer.sv - randomized self-checking bench for kuznechik_key_sequencer
module tb_kuznechik_key_sequencer;
  localparam int KEY_W  = 128;
  localparam int ROUNDS = 10;
  localparam int SLOTS  = 2;
  localparam int SLOT_W = 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               load_start = 1'b0;
  logic [SLOT_W-1:0]  load_slot = '0;
  logic               kg_ready = 1'b0;
  logic [2*KEY_W-1:0] kg_pair = '0;
  logic               load_busy;
  logic [SLOTS-1:0]   slot_valid;
  logic               start = 1'b0;
  logic [SLOT_W-1:0]  sel_slot = '0;
  logic               decrypt = 1'b0;
  logic               key_next = 1'b0;
  logic [KEY_W-1:0]   key_out;
  logic               key_valid;
  logic               seq_busy;
  logic               done;
  logic               err;
  logic [1:0]         err_code;

  kuznechik_key_sequencer #(.KEY_W(KEY_W), .ROUNDS(ROUNDS), .SLOTS(SLOTS), .SLOT_W(SLOT_W)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_slot(load_slot),
    .kg_ready(kg_ready), .kg_pair(kg_pair), .load_busy(load_busy), .slot_valid(slot_valid),
    .start(start), .sel_slot(sel_slot), .decrypt(decrypt), .key_next(key_next),
    .key_out(key_out), .key_valid(key_valid), .seq_busy(seq_busy), .done(done),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Reference model: what each slot should hold and which slots are complete.
  logic [KEY_W-1:0] ref_mem [SLOTS][ROUNDS];
  logic [SLOTS-1:0] ref_valid = '0;
  logic [KEY_W-1:0] new_keys [ROUNDS];

  logic [KEY_W-1:0] key_log[$];
  bit               done_log[$];
  int               key_cyc[$];
  logic [1:0]       err_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (key_valid) begin
      key_log.push_back(key_out);
      done_log.push_back(done);
      key_cyc.push_back(cyc);
    end
    if (err) err_log.push_back(err_code);
  end

  function automatic logic [KEY_W-1:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; start = 1'b0; load_start = 1'b0; kg_ready = 1'b0; key_next = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    ref_valid = '0;
  endtask

  task automatic gen_keys();
    for (int i = 0; i < ROUNDS; i++) new_keys[i] = rand_key();
  endtask

  task automatic commit_keys(input int slot);
    for (int i = 0; i < ROUNDS; i++) ref_mem[slot][i] = new_keys[i];
    ref_valid[slot] = 1'b1;
  endtask

  task automatic load_schedule(input int slot, input int spacing);
    gen_keys();
    load_start = 1'b1; load_slot = slot[SLOT_W-1:0];
    tick();
    load_start = 1'b0;
    ref_valid[slot] = 1'b0;
    for (int p = 0; p < ROUNDS / 2; p++) begin
      kg_ready = 1'b1; kg_pair = {new_keys[2*p], new_keys[2*p+1]};
      tick();
      kg_ready = 1'b0;
      repeat (spacing - 1) tick();
    end
    commit_keys(slot);
  endtask

  task automatic serve(input int slot, input bit dec, input bit gaps);
    int issued = 0;
    key_log.delete(); done_log.delete(); key_cyc.delete();
    start = 1'b1; sel_slot = slot[SLOT_W-1:0]; decrypt = dec;
    tick();
    start = 1'b0;
    for (int c = 0; c < 400 && issued < ROUNDS; c++) begin
      key_next = !gaps || ($urandom_range(0, 1) == 1);
      if (key_next) issued++;
      tick();
    end
    key_next = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    tests++; if (slot_valid !== '0) begin fails++; $display("FAIL reset_slot_valid got %b want 0", slot_valid); end
    tests++; if (load_busy !== 1'b0) begin fails++; $display("FAIL reset_load_busy got %b want 0", load_busy); end
    tests++; if (seq_busy !== 1'b0) begin fails++; $display("FAIL reset_seq_busy got %b want 0", seq_busy); end
    tests++; if (key_out !== '0) begin fails++; $display("FAIL reset_key_out got %h want 0", key_out); end
    tests++; if ({key_valid, done, err} !== 3'b000) begin fails++; $display("FAIL reset_strobes got %b want 000", {key_valid, done, err}); end
    tests++; if (err_code !== 2'd0) begin fails++; $display("FAIL reset_err_code got %0d want 0", err_code); end
    rst_n = 1'b1;
    tick();
    ref_valid = '0;
  endtask

  task automatic test_start_invalid();
    err_log.delete();
    start = 1'b1; sel_slot = 1'b1; decrypt = 1'b0;
    tick();
    start = 1'b0;
    tests++; if (seq_busy !== 1'b0) begin fails++; $display("FAIL inv_seq_busy got %b want 0", seq_busy); end
    tick(); tick();
    tests++; if (err_log.size() !== 1) begin fails++; $display("FAIL inv_err_count got %0d want 1", err_log.size()); end
    else begin
      tests++; if (err_log[0] !== 2'd1) begin fails++; $display("FAIL inv_err_code got %0d want 1", err_log[0]); end
    end
    tests++; if (err_code !== 2'd1 || err !== 1'b0) begin fails++; $display("FAIL inv_err_hold got err=%b code=%0d want err=0 code=1", err, err_code); end
    tests++; if (seq_busy !== 1'b0) begin fails++; $display("FAIL inv_seq_busy_late got %b want 0", seq_busy); end
  endtask

  task automatic test_forward();
    load_schedule(0, 3);
    tests++; if (slot_valid !== 2'b01) begin fails++; $display("FAIL fwd_slot_valid got %b want 01", slot_valid); end
    tests++; if (load_busy !== 1'b0) begin fails++; $display("FAIL fwd_load_busy got %b want 0", load_busy); end
    serve(0, 1'b0, 1'b0);
    tests++; if (key_log.size() !== ROUNDS) begin fails++; $display("FAIL fwd_count got %0d want %0d", key_log.size(), ROUNDS); end
    for (int i = 0; i < ROUNDS && i < key_log.size(); i++) begin
      tests++; if (key_log[i] !== ref_mem[0][i]) begin fails++; $display("FAIL fwd_key[%0d] got %h want %h", i, key_log[i], ref_mem[0][i]); end
      tests++; if (done_log[i] !== (i == ROUNDS - 1)) begin fails++; $display("FAIL fwd_done[%0d] got %b want %b", i, done_log[i], i == ROUNDS - 1); end
      tests++; if (key_cyc[i] - key_cyc[0] !== i) begin fails++; $display("FAIL fwd_spacing[%0d] got %0d want %0d", i, key_cyc[i] - key_cyc[0], i); end
    end
    tests++; if (seq_busy !== 1'b0) begin fails++; $display("FAIL fwd_idle got %b want 0", seq_busy); end
    key_log.delete();
    key_next = 1'b1; tick(); tick(); key_next = 1'b0; tick();
    tests++; if (key_log.size() !== 0) begin fails++; $display("FAIL idle_key_next got %0d keys want 0", key_log.size()); end
  endtask

  task automatic test_reverse();
    serve(0, 1'b1, 1'b0);
    tests++; if (key_log.size() !== ROUNDS) begin fails++; $display("FAIL rev_count got %0d want %0d", key_log.size(), ROUNDS); end
    for (int i = 0; i < ROUNDS && i < key_log.size(); i++) begin
      tests++; if (key_log[i] !== ref_mem[0][ROUNDS-1-i]) begin fails++; $display("FAIL rev_key[%0d] got %h want %h", i, key_log[i], ref_mem[0][ROUNDS-1-i]); end
      tests++; if (done_log[i] !== (i == ROUNDS - 1)) begin fails++; $display("FAIL rev_done[%0d] got %b want %b", i, done_log[i], i == ROUNDS - 1); end
    end
  endtask

  task automatic test_overrun();
    logic [KEY_W-1:0] junk;
    gen_keys();
    junk = rand_key();
    err_log.delete();
    load_start = 1'b1; load_slot = 1'b1;
    tick();
    load_start = 1'b0;
    ref_valid[1] = 1'b0;
    kg_ready = 1'b1; kg_pair = {new_keys[0], new_keys[1]};
    tick();
    kg_pair = {junk, junk};
    tick();
    kg_ready = 1'b0;
    tick();
    for (int p = 1; p < ROUNDS / 2; p++) begin
      if (p == ROUNDS / 2 - 1) begin
        tests++; if (slot_valid[1] !== 1'b0) begin fails++; $display("FAIL ovr_early_valid got %b want 0", slot_valid[1]); end
      end
      kg_ready = 1'b1; kg_pair = {new_keys[2*p], new_keys[2*p+1]};
      tick();
      kg_ready = 1'b0;
      tick(); tick();
    end
    commit_keys(1);
    tests++; if (slot_valid !== ref_valid) begin fails++; $display("FAIL ovr_slot_valid got %b want %b", slot_valid, ref_valid); end
    tests++; if (err_log.size() !== 1 || err_log[0] !== 2'd3) begin fails++; $display("FAIL ovr_err got %0d entries first=%0d want 1 entry code 3", err_log.size(), err_log.size() > 0 ? err_log[0] : 2'd0); end
    serve(1, 1'b0, 1'b1);
    tests++; if (key_log.size() !== ROUNDS) begin fails++; $display("FAIL ovr_count got %0d want %0d", key_log.size(), ROUNDS); end
    for (int i = 0; i < ROUNDS && i < key_log.size(); i++) begin
      tests++; if (key_log[i] !== ref_mem[1][i]) begin fails++; $display("FAIL ovr_key[%0d] got %h want %h", i, key_log[i], ref_mem[1][i]); end
    end
  endtask

  task automatic test_collision();
    int issued = 0;
    int pairs = 0;
    gen_keys();
    err_log.delete(); key_log.delete(); done_log.delete(); key_cyc.delete();
    start = 1'b1; sel_slot = 1'b0; decrypt = 1'b0;
    tick();
    start = 1'b0;
    load_start = 1'b1; load_slot = 1'b0;
    tick();
    tests++; if (load_busy !== 1'b0) begin fails++; $display("FAIL col_rejected_busy got %b want 0", load_busy); end
    load_slot = 1'b1;
    tick();
    load_start = 1'b0;
    ref_valid[1] = 1'b0;
    tests++; if (load_busy !== 1'b1) begin fails++; $display("FAIL col_accepted_busy got %b want 1", load_busy); end
    for (int c = 0; c < 300 && (issued < ROUNDS || pairs < ROUNDS / 2); c++) begin
      key_next = (issued < ROUNDS) && ($urandom_range(0, 1) == 1);
      if (key_next) issued++;
      kg_ready = (pairs < ROUNDS / 2) && (c % 3 == 0);
      if (kg_ready) begin
        kg_pair = {new_keys[2*pairs], new_keys[2*pairs+1]};
        pairs++;
      end
      tick();
    end
    key_next = 1'b0; kg_ready = 1'b0;
    tick(); tick();
    commit_keys(1);
    tests++; if (err_log.size() !== 1 || err_log[0] !== 2'd2) begin fails++; $display("FAIL col_err got %0d entries first=%0d want 1 entry code 2", err_log.size(), err_log.size() > 0 ? err_log[0] : 2'd0); end
    tests++; if (slot_valid !== 2'b11) begin fails++; $display("FAIL col_slot_valid got %b want 11", slot_valid); end
    tests++; if (key_log.size() !== ROUNDS) begin fails++; $display("FAIL col_srv_count got %0d want %0d", key_log.size(), ROUNDS); end
    for (int i = 0; i < ROUNDS && i < key_log.size(); i++) begin
      tests++; if (key_log[i] !== ref_mem[0][i]) begin fails++; $display("FAIL col_srv_key[%0d] got %h want %h", i, key_log[i], ref_mem[0][i]); end
    end
    serve(1, 1'b1, 1'b0);
    for (int i = 0; i < ROUNDS && i < key_log.size(); i++) begin
      tests++; if (key_log[i] !== ref_mem[1][ROUNDS-1-i]) begin fails++; $display("FAIL col_ld_key[%0d] got %h want %h", i, key_log[i], ref_mem[1][ROUNDS-1-i]); end
    end
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 4; it++) begin
      int  slot = $urandom_range(0, SLOTS - 1);
      bit  dec  = bit'($urandom_range(0, 1));
      load_schedule(slot, $urandom_range(2, 5));
      tests++; if (slot_valid !== ref_valid) begin fails++; $display("FAIL rnd%0d_slot_valid got %b want %b", it, slot_valid, ref_valid); end
      serve(slot, dec, 1'b1);
      tests++; if (key_log.size() !== ROUNDS) begin fails++; $display("FAIL rnd%0d_count got %0d want %0d", it, key_log.size(), ROUNDS); end
      for (int i = 0; i < ROUNDS && i < key_log.size(); i++) begin
        int idx = dec ? ROUNDS - 1 - i : i;
        tests++; if (key_log[i] !== ref_mem[slot][idx]) begin fails++; $display("FAIL rnd%0d_key[%0d] got %h want %h", it, i, key_log[i], ref_mem[slot][idx]); end
        tests++; if (done_log[i] !== (i == ROUNDS - 1)) begin fails++; $display("FAIL rnd%0d_done[%0d] got %b", it, i, done_log[i]); end
      end
    end
  endtask

  task automatic test_reset_midload();
    gen_keys();
    load_start = 1'b1; load_slot = 1'b0;
    tick();
    load_start = 1'b0;
    for (int p = 0; p < 3; p++) begin
      kg_ready = 1'b1; kg_pair = {new_keys[2*p], new_keys[2*p+1]};
      tick();
      kg_ready = 1'b0;
      tick(); tick();
    end
    #2 rst_n = 1'b0;
    #1;
    ref_valid = '0;
    tests++; if (slot_valid !== ref_valid) begin fails++; $display("FAIL rst_slot_valid got %b want %b", slot_valid, ref_valid); end
    tests++; if (load_busy !== 1'b0) begin fails++; $display("FAIL rst_load_busy got %b want 0", load_busy); end
    tick();
    rst_n = 1'b1;
    tick();
    err_log.delete();
    start = 1'b1; sel_slot = 1'b0; decrypt = 1'b0;
    tick();
    start = 1'b0;
    tick(); tick();
    tests++; if (err_log.size() !== 1 || err_log[0] !== 2'd1) begin fails++; $display("FAIL rst_start_err got %0d entries first=%0d want 1 entry code 1", err_log.size(), err_log.size() > 0 ? err_log[0] : 2'd0); end
    tests++; if (seq_busy !== 1'b0) begin fails++; $display("FAIL rst_seq_busy got %b want 0", seq_busy); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_start_invalid();
    test_forward();
    test_reverse();
    test_overrun();
    test_collision();
    test_back_to_back();
    apply_reset();
    test_reset_midload();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
